// File: rtl/vga_pkg.sv
// Shared raster constants for the default 640x480@60 timing and the coordinate type
// used by the timing generator and every pixel-colour block.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the colour blocks; all members are
// registered (or strobes gated by the registered pixel enable) in the producer.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic        pix_ce;
  coord_t      DrawX;
  coord_t      DrawY;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output pix_ce, DrawX, DrawY, hsync, vsync, active, line_start, frame_start, frame_cnt
  );

  modport slave (
    input pix_ce, DrawX, DrawY, hsync, vsync, active, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_pix_ce.sv
// Pixel clock-enable divider: one-clk pulse every PIX_DIV board clocks, the first
// one PIX_DIV clocks after reset is released.
module vga_pix_ce #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_ce
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  generate
    if (PIX_DIV < 1) begin : g_bad_div
      $error("vga_pix_ce: PIX_DIV must be >= 1");
    end
  endgenerate

  logic [DW-1:0] div;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters advanced by the pixel enable, with sync and
// active flags registered from next-state counters so they always match DrawX/DrawY.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam coord_t X_LAST     = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t Y_LAST     = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t X_ACTIVE   = coord_t'(H_ACTIVE);
  localparam coord_t Y_ACTIVE   = coord_t'(V_ACTIVE);
  localparam coord_t X_HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t X_HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t Y_VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t Y_VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic        pix_ce;
  coord_t      draw_x, draw_y;
  coord_t      x_next, y_next;
  logic        frame_wrap;
  logic        hsync_q, vsync_q, active_q;
  logic        x_zero_q, xy_zero_q;
  logic [15:0] frame_cnt_q;

  vga_pix_ce #(.PIX_DIV(PIX_DIV)) u_pix_ce (
    .clk    (clk),
    .reset  (reset),
    .pix_ce (pix_ce)
  );

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    x_next     = draw_x;
    y_next     = draw_y;
    frame_wrap = 1'b0;
    if (pix_ce) begin
      if (draw_x == X_LAST) begin
        x_next = '0;
        if (draw_y == Y_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = draw_y + 1'b1;
        end
      end else begin
        x_next = draw_x + 1'b1;
      end
    end
  end

  // Flags are computed from the next-state counters so they land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_x      <= '0;
      draw_y      <= '0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      active_q    <= 1'b1;
      x_zero_q    <= 1'b1;
      xy_zero_q   <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      draw_x    <= x_next;
      draw_y    <= y_next;
      hsync_q   <= ((x_next >= X_HS_START) && (x_next < X_HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_q   <= ((y_next >= Y_VS_START) && (y_next < Y_VS_END)) ? SYNC_POL : ~SYNC_POL;
      active_q  <= (x_next < X_ACTIVE) && (y_next < Y_ACTIVE);
      x_zero_q  <= (x_next == '0);
      xy_zero_q <= (x_next == '0) && (y_next == '0);
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Strobes are gated by pix_ce so they are exactly one clk wide.
  assign vga.pix_ce      = pix_ce;
  assign vga.DrawX       = draw_x;
  assign vga.DrawY       = draw_y;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.active      = active_q;
  assign vga.line_start  = pix_ce & x_zero_q;
  assign vga.frame_start = pix_ce & xy_zero_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule
